// File: rtl/serial_full_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell plus a borrow flop,
// computing diff = a - b - bin LSB-first, one bit per clock, with a done pulse.
module serial_full_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res_sr;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_r_next;
  logic [WIDTH-1:0] w_res_next;

  function automatic logic fs_diff(input logic x, input logic y, input logic r);
    return x ^ y ^ r;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic r);
    return (~x & y) | (~(x ^ y) & r);
  endfunction

  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last     = (r_cnt == LAST_BIT);
  assign w_d        = fs_diff(r_a_sr[0], r_b_sr[0], r_borrow);
  assign w_r_next   = fs_borrow(r_a_sr[0], r_b_sr[0], r_borrow);
  // New bit enters at the MSB; after WIDTH shifts the first bit sits at bit 0.
  assign w_res_next = (r_res_sr >> 1) | {w_d, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_SHIFT : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res_sr <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (r_state == S_SHIFT) begin
      r_a_sr   <= r_a_sr >> 1;
      r_b_sr   <= r_b_sr >> 1;
      r_borrow <= w_r_next;
      r_res_sr <= w_res_next;
      r_cnt    <= r_cnt + CNT_W'(1);
      // Outputs change only on entry to DONE, so partial results never show.
      if (w_last) begin
        r_diff <= w_res_next;
        r_bout <= w_r_next;
      end
    end
  end

  assign busy = (r_state == S_SHIFT);
  assign done = (r_state == S_DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule
